// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared constants for the single-cycle MIPS core: opcode values, register
// index constants, instruction field positions, and a helper that classifies
// the immediate-extension mode of an opcode.
// ----------------------------------------------------------------------------
package mips_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;

   // Instruction field positions (LSB of each field) and widths.
   localparam int unsigned OP_LSB = 26;
   localparam int unsigned OP_W   = 6;
   localparam int unsigned RS_LSB = 21;
   localparam int unsigned RT_LSB = 16;
   localparam int unsigned RD_LSB = 11;
   localparam int unsigned IMM_W  = 16;

   typedef logic [OP_W-1:0]   opcode_t;
   typedef logic [REG_AW-1:0] reg_idx_t;

   localparam opcode_t OP_ANDI = 6'b001100;
   localparam opcode_t OP_ORI  = 6'b001101;
   localparam opcode_t OP_XORI = 6'b001110;
   localparam opcode_t OP_JAL  = 6'b000011;

   localparam reg_idx_t REG_ZERO = 5'd0;
   localparam reg_idx_t REG_SP   = 5'd29;
   localparam reg_idx_t REG_RA   = 5'd31;

   // Only the logical immediates zero-extend; everything else (sltiu and lui
   // included) sign-extends.
   function automatic logic is_zero_ext(input opcode_t op);
      return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
   endfunction

endpackage

// File: rtl/regfile32.sv
// ----------------------------------------------------------------------------
// regfile32
// 32x32 general register file. Register 0 is not stored and reads as zero;
// registers 1..31 reset asynchronously to zero except $sp, which loads SP_INIT.
//
// Ports:
//   i_clock     write clock (rising edge)
//   i_reset_n   asynchronous active-low reset
//   i_we        write enable
//   i_waddr     write index (writes to index 0 are dropped)
//   i_wdata     write data
//   i_rs_addr   read port A index   -> o_rs_data
//   i_rt_addr   read port B index   -> o_rt_data
//   i_dbg_addr  debug read index    -> o_dbg_data
// ----------------------------------------------------------------------------
module regfile32
   import mips_pkg::*;
#(
   parameter logic [XLEN-1:0] SP_INIT = 32'h0000_7FFC
) (
   input  logic              i_clock,
   input  logic              i_reset_n,
   input  logic              i_we,
   input  logic [REG_AW-1:0] i_waddr,
   input  logic [XLEN-1:0]   i_wdata,
   input  logic [REG_AW-1:0] i_rs_addr,
   input  logic [REG_AW-1:0] i_rt_addr,
   input  logic [REG_AW-1:0] i_dbg_addr,
   output logic [XLEN-1:0]   o_rs_data,
   output logic [XLEN-1:0]   o_rt_data,
   output logic [XLEN-1:0]   o_dbg_data
);

   logic [XLEN-1:0] r_regs [1:31];

   // NOTE: this array is reset like ordinary flops rather than left to power-up
   // contents, so no X can ever leak out of a read port; that forces flop
   // storage instead of a RAM macro, which is acceptable at 31 entries.
   // NOTE: sequential state uses non-blocking assignments so every read port
   // sees the pre-edge value during the cycle that writes it (no bypass).
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 1; i < 32; i++) begin
            r_regs[i] <= (REG_AW'(i) == REG_SP) ? SP_INIT : '0;
         end
      end else if (i_we && (i_waddr != REG_ZERO)) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   assign o_rs_data  = (i_rs_addr  == REG_ZERO) ? '0 : r_regs[i_rs_addr];
   assign o_rt_data  = (i_rt_addr  == REG_ZERO) ? '0 : r_regs[i_rt_addr];
   assign o_dbg_data = (i_dbg_addr == REG_ZERO) ? '0 : r_regs[i_dbg_addr];

endmodule

// File: rtl/operand_decode.sv
// ----------------------------------------------------------------------------
// operand_decode
// Decode / register-file stage of the single-cycle MIPS core. Splits the
// instruction into fields, extends the immediate, reads rs/rt combinationally
// and writes back ALU result, load data or the jal link address at the edge.
//
// Ports:
//   clock, reset_n    core clock; asynchronous active-low reset
//   Instruction       current instruction from fetch
//   ALU_Result        execute-stage result (default write data)
//   Mem_data          load data (write data when MemtoReg)
//   PC_plus_4         link value (write data when Jal)
//   RegWrite, RegDst, MemtoReg, Jal   controller strobes
//   Read_data_1/2     register[rs] / register[rt]
//   Sign_extend       extended 16-bit immediate
//   Dbg_addr/Dbg_data debug register read port
// ----------------------------------------------------------------------------
module operand_decode
   import mips_pkg::*;
#(
   parameter logic [XLEN-1:0]   SP_INIT  = 32'h0000_7FFC,
   parameter logic [REG_AW-1:0] RA_INDEX = REG_RA
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [XLEN-1:0]   Instruction,
   input  logic [XLEN-1:0]   ALU_Result,
   input  logic [XLEN-1:0]   Mem_data,
   input  logic [XLEN-1:0]   PC_plus_4,
   input  logic              RegWrite,
   input  logic              RegDst,
   input  logic              MemtoReg,
   input  logic              Jal,
   output logic [XLEN-1:0]   Read_data_1,
   output logic [XLEN-1:0]   Read_data_2,
   output logic [XLEN-1:0]   Sign_extend,
   input  logic [REG_AW-1:0] Dbg_addr,
   output logic [XLEN-1:0]   Dbg_data
);

   opcode_t            w_opcode;
   logic [REG_AW-1:0]  w_rs;
   logic [REG_AW-1:0]  w_rt;
   logic [REG_AW-1:0]  w_rd;
   logic [IMM_W-1:0]   w_imm;
   logic [REG_AW-1:0]  w_dest;
   logic [XLEN-1:0]    w_wdata;
   logic               w_we;

   assign w_opcode = Instruction[OP_LSB +: OP_W];
   assign w_rs     = Instruction[RS_LSB +: REG_AW];
   assign w_rt     = Instruction[RT_LSB +: REG_AW];
   assign w_rd     = Instruction[RD_LSB +: REG_AW];
   assign w_imm    = Instruction[0 +: IMM_W];

   // NOTE: every output of this always_comb is given a default first, so no
   // path through it can leave a value held and infer a latch.
   always_comb begin
      Sign_extend = {{(XLEN-IMM_W){w_imm[IMM_W-1]}}, w_imm};
      if (is_zero_ext(w_opcode)) begin
         Sign_extend = {{(XLEN-IMM_W){1'b0}}, w_imm};
      end
   end

   // Jal dominates both muxes: it must link even when the controller also
   // raises RegDst or MemtoReg.
   always_comb begin
      w_dest  = w_rt;
      w_wdata = ALU_Result;
      if (Jal) begin
         w_dest  = RA_INDEX;
         w_wdata = PC_plus_4;
      end else begin
         if (RegDst)   w_dest  = w_rd;
         if (MemtoReg) w_wdata = Mem_data;
      end
   end

   assign w_we = RegWrite | Jal;

   regfile32 #(
      .SP_INIT (SP_INIT)
   ) u_regfile (
      .i_clock    (clock),
      .i_reset_n  (reset_n),
      .i_we       (w_we),
      .i_waddr    (w_dest),
      .i_wdata    (w_wdata),
      .i_rs_addr  (w_rs),
      .i_rt_addr  (w_rt),
      .i_dbg_addr (Dbg_addr),
      .o_rs_data  (Read_data_1),
      .o_rt_data  (Read_data_2),
      .o_dbg_data (Dbg_data)
   );

endmodule

// File: tb/tb_operand_decode.sv
// ----------------------------------------------------------------------------
// tb_operand_decode
// Self-checking bench for operand_decode: immediate-extension table,
// write-back vector table with a write scoreboard and a shadow register model,
// and hand-written reset sequences.
// ----------------------------------------------------------------------------
module tb_operand_decode;

   localparam logic [31:0] SP_INIT = 32'h0000_7FFC;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] Instruction, ALU_Result, Mem_data, PC_plus_4;
   logic        RegWrite, RegDst, MemtoReg, Jal;
   logic [31:0] Read_data_1, Read_data_2, Sign_extend, Dbg_data;
   logic [4:0]  Dbg_addr;

   operand_decode #(
      .SP_INIT  (SP_INIT),
      .RA_INDEX (5'd31)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .Instruction (Instruction),
      .ALU_Result  (ALU_Result),
      .Mem_data    (Mem_data),
      .PC_plus_4   (PC_plus_4),
      .RegWrite    (RegWrite),
      .RegDst      (RegDst),
      .MemtoReg    (MemtoReg),
      .Jal         (Jal),
      .Read_data_1 (Read_data_1),
      .Read_data_2 (Read_data_2),
      .Sign_extend (Sign_extend),
      .Dbg_addr    (Dbg_addr),
      .Dbg_data    (Dbg_data)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] model_rf [32];

   typedef struct {
      logic [4:0]  idx;
      logic [31:0] val;
   } wr_t;
   wr_t sb_q[$];

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [31:0] exp_ext;
   } imm_vec_t;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic        regwrite, regdst, memtoreg, jal;
      logic [31:0] alu, mem, pc4;
      logic        exp_we;     // a stored register changes
      logic [4:0]  exp_idx;
      logic [31:0] exp_val;
   } wr_vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] r_type(input logic [4:0] rs, rt, rd);
      return {6'h00, rs, rt, rd, 5'd0, 6'h21};
   endfunction

   function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic idle_inputs();
      RegWrite = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      Jal      = 1'b0;
   endtask

   task automatic sweep(input string tag);
      for (int i = 0; i < 32; i++) begin
         Dbg_addr = 5'(i);
         #1;
         check($sformatf("%s dbg[%0d]", tag, i), Dbg_data, model_rf[i]);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) model_rf[i] = (i == 29) ? SP_INIT : 32'h0;
   endtask

   imm_vec_t imm_tbl[7];
   wr_vec_t  wr_tbl[8];

   initial begin
      imm_tbl[0] = '{"andi 8001",  i_type(6'h0C, 5'd1, 5'd2, 16'h8001), 32'h0000_8001};
      imm_tbl[1] = '{"addi 8001",  i_type(6'h08, 5'd1, 5'd2, 16'h8001), 32'hFFFF_8001};
      imm_tbl[2] = '{"sltiu FFFF", i_type(6'h0B, 5'd1, 5'd2, 16'hFFFF), 32'hFFFF_FFFF};
      imm_tbl[3] = '{"ori FFFF",   i_type(6'h0D, 5'd1, 5'd2, 16'hFFFF), 32'h0000_FFFF};
      imm_tbl[4] = '{"xori 8000",  i_type(6'h0E, 5'd1, 5'd2, 16'h8000), 32'h0000_8000};
      imm_tbl[5] = '{"lui 8000",   i_type(6'h0F, 5'd0, 5'd2, 16'h8000), 32'hFFFF_8000};
      imm_tbl[6] = '{"addiu 7FFF", i_type(6'h09, 5'd1, 5'd2, 16'h7FFF), 32'h0000_7FFF};

      //               name          instr                                  rw    rdst  m2r   jal   alu            mem            pc4            we    idx    val
      wr_tbl[0] = '{"addu $8",   r_type(5'd9, 5'd10, 5'd8),              1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0,         32'h0,         1'b1, 5'd8,  32'hDEAD_BEEF};
      wr_tbl[1] = '{"write $0",  r_type(5'd8, 5'd5, 5'd0),               1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0,         32'h0,         1'b0, 5'd0,  32'h0};
      wr_tbl[2] = '{"jal link",  {6'h03, 26'h40},                        1'b0, 1'b0, 1'b0, 1'b1, 32'h1111_1111, 32'h2222_2222, 32'h0000_0104, 1'b1, 5'd31, 32'h0000_0104};
      wr_tbl[3] = '{"lw $5",     i_type(6'h23, 5'd8, 5'd5, 16'h3800),    1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'hA5A5_0001, 32'h0,         1'b1, 5'd5,  32'hA5A5_0001};
      wr_tbl[4] = '{"jal+rdst",  r_type(5'd31, 5'd5, 5'd12),             1'b1, 1'b1, 1'b1, 1'b1, 32'h3333_3333, 32'h4444_4444, 32'h0000_0200, 1'b1, 5'd31, 32'h0000_0200};
      wr_tbl[5] = '{"no write",  r_type(5'd5, 5'd8, 5'd9),               1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0077, 32'h0,         32'h0,         1'b0, 5'd9,  32'h0};
      wr_tbl[6] = '{"addu $29",  r_type(5'd29, 5'd31, 5'd29),            1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_CAFE, 32'h0,         32'h0,         1'b1, 5'd29, 32'h0000_CAFE};
      wr_tbl[7] = '{"addiu $7",  i_type(6'h09, 5'd29, 5'd7, 16'h0055),   1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0055, 32'h0,         32'h0,         1'b1, 5'd7,  32'h0000_0055};
   end

   initial begin
      reset_n     = 1'b0;
      Instruction = i_type(6'h09, 5'd29, 5'd29, 16'h0);
      ALU_Result  = 32'hFFFF_FFFF;
      Mem_data    = 32'h0;
      PC_plus_4   = 32'h0;
      Dbg_addr    = 5'd0;
      RegWrite    = 1'b1;   // a write request under reset must be ignored
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      Jal         = 1'b0;
      model_reset();

      // Reset state, held over several edges.
      repeat (2) @(posedge clock);
      #2;
      check("reset rd1 $29", Read_data_1, SP_INIT);
      check("reset rd2 $29", Read_data_2, SP_INIT);
      sweep("reset");
      idle_inputs();
      @(negedge clock);
      reset_n = 1'b1;

      // Immediate extension table.
      foreach (imm_tbl[k]) begin
         Instruction = imm_tbl[k].instr;
         #1;
         check({"ext ", imm_tbl[k].name}, Sign_extend, imm_tbl[k].exp_ext);
      end

      // Write-back table.
      foreach (wr_tbl[k]) begin
         @(negedge clock);
         Instruction = wr_tbl[k].instr;
         RegWrite    = wr_tbl[k].regwrite;
         RegDst      = wr_tbl[k].regdst;
         MemtoReg    = wr_tbl[k].memtoreg;
         Jal         = wr_tbl[k].jal;
         ALU_Result  = wr_tbl[k].alu;
         Mem_data    = wr_tbl[k].mem;
         PC_plus_4   = wr_tbl[k].pc4;
         Dbg_addr    = wr_tbl[k].exp_idx;
         #1;
         // Pre-edge: reads still show the old contents.
         check({wr_tbl[k].name, " pre rd1"}, Read_data_1, model_rf[wr_tbl[k].instr[25:21]]);
         check({wr_tbl[k].name, " pre rd2"}, Read_data_2, model_rf[wr_tbl[k].instr[20:16]]);
         check({wr_tbl[k].name, " pre dest"}, Dbg_data, model_rf[wr_tbl[k].exp_idx]);
         if (wr_tbl[k].exp_we) sb_q.push_back('{wr_tbl[k].exp_idx, wr_tbl[k].exp_val});
         @(posedge clock);
         #1;
         idle_inputs();
         while (sb_q.size() > 0) begin
            wr_t w;
            w = sb_q.pop_front();
            model_rf[w.idx] = w.val;
            Dbg_addr = w.idx;
            #1;
            check({wr_tbl[k].name, " post"}, Dbg_data, w.val);
         end
         Instruction = r_type(wr_tbl[k].exp_idx, 5'd0, 5'd0);
         #1;
         check({wr_tbl[k].name, " post rd1"}, Read_data_1, model_rf[wr_tbl[k].exp_idx]);
         sweep(wr_tbl[k].name);
      end

      // Reset asserted mid-cycle with a write to $7 pending.
      @(negedge clock);
      Instruction = i_type(6'h09, 5'd7, 5'd7, 16'h0099);
      RegWrite    = 1'b1;
      ALU_Result  = 32'h0000_0099;
      Dbg_addr    = 5'd7;
      #1;
      check("pending $7 old", Dbg_data, 32'h0000_0055);
      reset_n = 1'b0;
      #1;
      check("midreset $7", Dbg_data, 32'h0);
      check("midreset rd1 $7", Read_data_1, 32'h0);
      model_reset();
      @(posedge clock);
      #1;
      check("held reset $7", Dbg_data, 32'h0);
      sweep("held reset");

      // Release between edges; the still-pending write lands on the next edge.
      @(negedge clock);
      reset_n = 1'b1;
      Dbg_addr = 5'd7;
      #1;
      check("release pre $7", Dbg_data, 32'h0);
      @(posedge clock);
      #1;
      idle_inputs();
      model_rf[7] = 32'h0000_0099;
      check("release post $7", Dbg_data, 32'h0000_0099);
      sweep("after release");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
